// File: rtl/sync_demod_if.sv
// Sample stream in and I/Q result stream out of the synchronous demodulator.
// The slave modport is the demodulator's view; master is the source/consumer.
interface sync_demod_if #(
    parameter int DW    = 12,
    parameter int ACC_W = 24
);
    logic                    in_valid;
    logic signed [DW-1:0]    in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_i;
    logic signed [ACC_W-1:0] out_q;
    logic                    out_sat;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_i, out_q, out_sat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_i, out_q, out_sat
    );
endinterface

// File: rtl/sync_demod.sv
// Lock-in demodulator: square-wave I/Q mixing of sampled mixer output,
// saturating integration over dump_len LO periods, single-entry result register.
//
// state  | meaning
// IDLE   | phase, period counter and accumulators held at 0
// RUN    | accepting samples, integrating, dumping on the final period wrap
module sync_demod #(
    parameter int DW      = 12,
    parameter int PHASE_W = 16,
    parameter int ACC_W   = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [PHASE_W-1:0] lo_step,
    input  logic [7:0]         dump_len,
    output logic               lo_out,
    output logic               ovf,
    sync_demod_if.slave        bus
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t r_state, w_state_next;

    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] r_step;
    logic [7:0]         r_len;
    logic [7:0]         r_cnt;
    logic [ACC_W-1:0]   r_acc_i;
    logic [ACC_W-1:0]   r_acc_q;
    logic               r_sat;

    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_i;
    logic [ACC_W-1:0]   r_out_q;
    logic               r_out_sat;
    logic               r_ovf;

    logic               w_start;
    logic               w_hold;
    logic               w_accept;
    logic               w_sign_i_pos;
    logic               w_sign_q_pos;
    logic [ACC_W:0]     w_sample;
    logic [ACC_W:0]     w_sum_i;
    logic [ACC_W:0]     w_sum_q;
    logic               w_ovp_i, w_ovn_i, w_ovp_q, w_ovn_q;
    logic [ACC_W-1:0]   w_new_i;
    logic [ACC_W-1:0]   w_new_q;
    logic               w_sat_new;
    logic [PHASE_W:0]   w_phase_sum;
    logic               w_wrap;
    logic [7:0]         w_cnt_inc;
    logic               w_dump;
    logic               w_load;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state: enable alone decides between IDLE and RUN
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (enable)  w_state_next = S_RUN;
            S_RUN:   if (!enable) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_start  = (r_state == S_IDLE) && enable;
    // Datapath is cleared in IDLE and on the edge that leaves RUN
    assign w_hold   = (r_state == S_IDLE) || !enable;
    assign w_accept = !w_hold && bus.in_valid;

    // Square-wave references from the two phase MSBs; I leads Q by a quarter period
    assign w_sign_i_pos = ~(r_phase[PHASE_W-1] ^ r_phase[PHASE_W-2]);
    assign w_sign_q_pos = ~r_phase[PHASE_W-1];

    // One guard bit above the accumulator makes overflow visible for clipping
    assign w_sample = {{(ACC_W+1-DW){bus.in_data[DW-1]}}, bus.in_data};
    assign w_sum_i  = w_sign_i_pos ? ({r_acc_i[ACC_W-1], r_acc_i} + w_sample)
                                   : ({r_acc_i[ACC_W-1], r_acc_i} - w_sample);
    assign w_sum_q  = w_sign_q_pos ? ({r_acc_q[ACC_W-1], r_acc_q} + w_sample)
                                   : ({r_acc_q[ACC_W-1], r_acc_q} - w_sample);

    assign w_ovp_i = ~w_sum_i[ACC_W] &  w_sum_i[ACC_W-1];
    assign w_ovn_i =  w_sum_i[ACC_W] & ~w_sum_i[ACC_W-1];
    assign w_ovp_q = ~w_sum_q[ACC_W] &  w_sum_q[ACC_W-1];
    assign w_ovn_q =  w_sum_q[ACC_W] & ~w_sum_q[ACC_W-1];

    assign w_new_i = w_ovp_i ? ACC_MAX : (w_ovn_i ? ACC_MIN : w_sum_i[ACC_W-1:0]);
    assign w_new_q = w_ovp_q ? ACC_MAX : (w_ovn_q ? ACC_MIN : w_sum_q[ACC_W-1:0]);
    assign w_sat_new = r_sat | w_ovp_i | w_ovn_i | w_ovp_q | w_ovn_q;

    // Carry out of the phase add marks the end of an LO period
    assign w_phase_sum = {1'b0, r_phase} + {1'b0, r_step};
    assign w_wrap      = w_phase_sum[PHASE_W];
    assign w_cnt_inc   = r_cnt + 8'd1;
    // r_len is never 0, so r_cnt stays below 255 and the increment cannot roll
    assign w_dump      = w_accept && w_wrap && (w_cnt_inc == r_len);
    assign w_load      = w_dump && (!r_out_valid || bus.out_ready);

    // Phase, period count and integration state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
            r_step  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_acc_i <= '0;
            r_acc_q <= '0;
            r_sat   <= 1'b0;
        end else if (w_hold) begin
            r_phase <= '0;
            r_cnt   <= '0;
            r_acc_i <= '0;
            r_acc_q <= '0;
            r_sat   <= 1'b0;
            if (w_start) begin
                r_step <= lo_step;
                r_len  <= (dump_len == 8'd0) ? 8'd1 : dump_len;
            end
        end else if (bus.in_valid) begin
            r_phase <= w_phase_sum[PHASE_W-1:0];
            if (w_dump) begin
                r_cnt   <= '0;
                r_acc_i <= '0;
                r_acc_q <= '0;
                r_sat   <= 1'b0;
            end else begin
                r_cnt   <= w_wrap ? w_cnt_inc : r_cnt;
                r_acc_i <= w_new_i;
                r_acc_q <= w_new_q;
                r_sat   <= w_sat_new;
            end
        end
    end

    // Output register: load on dump when free or draining, otherwise keep old result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_i     <= '0;
            r_out_q     <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_i     <= w_new_i;
            r_out_q     <= w_new_q;
            r_out_sat   <= w_sat_new;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky drop flag, cleared only when a new run starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     r_ovf <= 1'b0;
        else if (w_start)                            r_ovf <= 1'b0;
        else if (w_dump && r_out_valid && !bus.out_ready) r_ovf <= 1'b1;
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_i     = r_out_i;
    assign bus.out_q     = r_out_q;
    assign bus.out_sat   = r_out_sat;
    assign ovf           = r_ovf;
    assign lo_out        = w_sign_i_pos;
endmodule

// File: tb/tb_sync_demod.sv
// Bench for sync_demod: directed scenarios plus random traffic against a
// quadrant/period-level reference model of the lock-in demodulator.
module tb_sync_demod;
    localparam int DW      = 12;
    localparam int PHASE_W = 16;
    localparam int ACC_W   = 16;
    localparam longint MAXV = 32767;
    localparam longint MINV = -32768;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] lo_step;
    logic [7:0]  dump_len;
    logic        lo_out;
    logic        ovf;

    sync_demod_if #(.DW(DW), .ACC_W(ACC_W)) bus ();

    sync_demod #(.DW(DW), .PHASE_W(PHASE_W), .ACC_W(ACC_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .lo_step  (lo_step),
        .dump_len (dump_len),
        .lo_out   (lo_out),
        .ovf      (ovf),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit     m_run;
    int     m_phase, m_cnt, m_step, m_len;
    longint m_ai, m_aq;
    bit     m_sat;
    bit     m_ov, m_os, m_ovf;
    longint m_oi, m_oq;

    int pat[4];

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_phase = 0; m_cnt = 0; m_step = 0; m_len = 0;
        m_ai = 0; m_aq = 0; m_sat = 0;
        m_ov = 0; m_os = 0; m_ovf = 0; m_oi = 0; m_oq = 0;
    endtask

    function automatic longint clamp(input longint v, inout bit s);
        if (v > MAXV) begin s = 1; return MAXV; end
        if (v < MINV) begin s = 1; return MINV; end
        return v;
    endfunction

    // Advance the model by one clock edge using the pre-edge inputs
    task automatic model_edge(input bit en, input bit v, input int d, input bit rdy);
        bit hs, dump;
        int quad, si, sq, np;
        longint ai, aq;
        bit s;
        hs = m_ov && rdy;
        dump = 0;
        if (!m_run) begin
            if (en) begin
                m_run = 1; m_step = lo_step; m_len = (dump_len == 0) ? 1 : dump_len;
                m_ovf = 0;
            end
        end else if (!en) begin
            m_run = 0; m_phase = 0; m_cnt = 0; m_ai = 0; m_aq = 0; m_sat = 0;
        end else if (v) begin
            quad = m_phase / 16384;
            si = (quad == 0 || quad == 3) ? 1 : -1;
            sq = (quad < 2) ? 1 : -1;
            s  = m_sat;
            ai = clamp(m_ai + si * d, s);
            aq = clamp(m_aq + sq * d, s);
            np = m_phase + m_step;
            m_phase = np % 65536;
            m_ai = ai; m_aq = aq; m_sat = s;
            if (np >= 65536) begin
                m_cnt++;
                if (m_cnt == m_len) begin
                    dump = 1;
                    m_cnt = 0; m_ai = 0; m_aq = 0; m_sat = 0;
                end
            end
            if (dump) begin
                if (!m_ov || rdy) begin
                    m_ov = 1; m_oi = ai; m_oq = aq; m_os = s;
                end else begin
                    m_ovf = 1;
                end
            end
        end
        if (!dump && hs) m_ov = 0;
    endtask

    task automatic check_all();
        int quad;
        quad = m_phase / 16384;
        chk("out_valid", bus.out_valid, m_ov);
        chk("out_i", $signed(bus.out_i), m_oi);
        chk("out_q", $signed(bus.out_q), m_oq);
        chk("out_sat", bus.out_sat, m_os);
        chk("ovf", ovf, m_ovf);
        chk("lo_out", lo_out, (quad == 0 || quad == 3) ? 1 : 0);
    endtask

    task automatic cyc(input bit en, input bit v, input int d, input bit rdy);
        logic [31:0] dv;
        dv = d;
        enable       = en;
        bus.in_valid = v;
        bus.in_data  = dv[DW-1:0];
        bus.out_ready = rdy;
        model_edge(en, v, d, rdy);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        pat[0] = 100; pat[1] = -100; pat[2] = -100; pat[3] = 100;
        rst = 1'b1; enable = 1'b0; lo_step = 16'd16384; dump_len = 8'd1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        model_reset();
        #12;
        check_all();
        #10;
        rst = 1'b0;

        // DC rejection
        cyc(1, 0, 0, 1);
        for (int k = 0; k < 4; k++) cyc(1, 1, 100, 1);
        chk("dc_valid", bus.out_valid, 1);
        chk("dc_i", $signed(bus.out_i), 0);
        chk("dc_q", $signed(bus.out_q), 0);
        chk("dc_sat", bus.out_sat, 0);
        cyc(0, 0, 0, 1);

        // matched tone over two periods
        dump_len = 8'd2;
        cyc(1, 0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            cyc(1, 1, pat[k % 4], 1);
            if (k == 6) chk("tone_early", bus.out_valid, 0);
        end
        chk("tone_valid", bus.out_valid, 1);
        chk("tone_i", $signed(bus.out_i), 800);
        chk("tone_q", $signed(bus.out_q), 0);
        cyc(0, 0, 0, 1);

        // backpressure: second result dropped
        dump_len = 8'd1;
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 8; k++) cyc(1, 1, (k < 4) ? pat[k % 4] : 2 * pat[k % 4], 0);
        chk("bp_i", $signed(bus.out_i), 400);
        chk("bp_ovf", ovf, 1);
        cyc(1, 0, 0, 1);
        chk("bp_drain", bus.out_valid, 0);
        chk("bp_i_kept", $signed(bus.out_i), 400);
        cyc(1, 0, 0, 1);
        chk("bp_ovf_sticky", ovf, 1);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        chk("bp_ovf_clear", ovf, 0);
        cyc(0, 0, 0, 1);

        // saturation over 255 periods
        dump_len = 8'd255;
        cyc(1, 0, 0, 1);
        for (int k = 0; k < 1020; k++) cyc(1, 1, (pat[k % 4] > 0) ? 2047 : -2047, 1);
        chk("sat_i", $signed(bus.out_i), 32767);
        chk("sat_flag", bus.out_sat, 1);
        cyc(0, 0, 0, 1);

        // asynchronous reset mid-integration
        dump_len = 8'd1;
        cyc(1, 0, 0, 1);
        cyc(1, 1, pat[0], 1);
        cyc(1, 1, pat[1], 1);
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 0, 0, 1);
        for (int k = 0; k < 4; k++) cyc(1, 1, pat[k], 1);
        chk("rst_i", $signed(bus.out_i), 400);
        cyc(0, 0, 0, 1);

        // enable drop discards the partial integration
        cyc(1, 0, 0, 1);
        for (int k = 0; k < 3; k++) cyc(1, 1, pat[k], 1);
        cyc(0, 1, pat[3], 1);
        chk("drop_nodump", bus.out_valid, 0);
        cyc(1, 0, 0, 1);
        for (int k = 0; k < 4; k++) cyc(1, 1, pat[k], 1);
        chk("drop_i", $signed(bus.out_i), 400);

        // random traffic
        for (int b = 0; b < 30; b++) begin
            cyc(0, 0, 0, 1);
            lo_step  = 16'($urandom_range(2048, 65535));
            dump_len = 8'($urandom_range(0, 4));
            for (int k = 0; k < 100; k++) begin
                cyc($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
                    int'($urandom_range(0, 4095)) - 2048, $urandom_range(0, 3) != 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
